// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED level controller.
package led_ctrl_pkg;

    localparam int unsigned LEVEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } step_state_t;

    // Active-low {g,f,e,d,c,b,a} glyphs, hex letters for 10..15.
    function automatic logic [6:0] seg7_hex_n(input logic [3:0] v);
        logic [6:0] g;
        g = 7'h7F;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            4'hF: g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count filter for one raw button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            db     <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            // Any sample agreeing with db restarts the run of differing samples.
            if (sync_2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_level_ctrl.sv
// Up/down buttons to a debounced, auto-repeating brightness level with a 7-segment readout.
module led_level_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC     = 1000000,
    parameter int unsigned REPEAT_DELAY_CYC = 50000000,
    parameter int unsigned REPEAT_RATE_CYC  = 10000000,
    parameter int unsigned MAX_LEVEL        = 9,
    parameter bit          WRAP             = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_dn,
    output logic [LEVEL_W-1:0] level,
    output logic               level_chg,
    output logic [6:0]         seg_n
);

    localparam int unsigned TMR_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                                      REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int unsigned TMR_W = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0]   DELAY_LOAD = TMR_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [TMR_W-1:0]   RATE_LOAD  = TMR_W'(REPEAT_RATE_CYC - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]         db;
    logic [1:0]         step;
    step_state_t        state    [2];
    step_state_t        state_nx [2];
    logic [TMR_W-1:0]   tmr      [2];
    logic [TMR_W-1:0]   tmr_nx   [2];
    logic [LEVEL_W-1:0] level_nx;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_up (
        .clk (clk),
        .rst (rst),
        .raw (btn_up),
        .db  (db[0])
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_dn (
        .clk (clk),
        .rst (rst),
        .raw (btn_dn),
        .db  (db[1])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= IDLE;
                tmr[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                state[i] <= state_nx[i];
                tmr[i]   <= tmr_nx[i];
            end
        end
    end

    // Release is tested before timer expiry so it always suppresses the step.
    always_comb begin
        step = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            state_nx[i] = state[i];
            tmr_nx[i]   = tmr[i];
            case (state[i])
                IDLE: begin
                    if (db[i]) begin
                        step[i]     = 1'b1;
                        state_nx[i] = DELAY;
                        tmr_nx[i]   = DELAY_LOAD;
                    end
                end
                DELAY, REPEAT: begin
                    if (!db[i]) begin
                        state_nx[i] = IDLE;
                    end else if (tmr[i] == '0) begin
                        step[i]     = 1'b1;
                        state_nx[i] = REPEAT;
                        tmr_nx[i]   = RATE_LOAD;
                    end else begin
                        tmr_nx[i] = tmr[i] - TMR_W'(1);
                    end
                end
                default: state_nx[i] = IDLE;
            endcase
        end
    end

    always_comb begin
        level_nx = level;
        if (step == 2'b01) begin
            level_nx = (level == LEVEL_MAX) ? (WRAP ? '0 : level) : level + LEVEL_W'(1);
        end else if (step == 2'b10) begin
            level_nx = (level == '0) ? (WRAP ? LEVEL_MAX : level) : level - LEVEL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level     <= '0;
            level_chg <= 1'b0;
            seg_n     <= 7'b1000000;
        end else begin
            level     <= level_nx;
            level_chg <= (level_nx != level);
            seg_n     <= seg7_hex_n(level);
        end
    end

endmodule

// File: tb/tb_led_level_ctrl.sv
// Bench for led_level_ctrl: wrapping and saturating instances against a behavioural model.
module tb_led_level_ctrl;

    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RR   = 5;
    localparam int MAXL = 9;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_dn = 1'b0;
    logic [3:0] level     [2];
    logic       level_chg [2];
    logic [6:0] seg_n     [2];

    int checks = 0;
    int errors = 0;
    int cyc, pulses, first_at;

    // Instance 0 wraps at the bounds, instance 1 saturates.
    led_level_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR),
                     .MAX_LEVEL(MAXL), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .level(level[0]), .level_chg(level_chg[0]), .seg_n(seg_n[0])
    );

    led_level_ctrl #(.DEBOUNCE_CYC(D), .REPEAT_DELAY_CYC(RD), .REPEAT_RATE_CYC(RR),
                     .MAX_LEVEL(MAXL), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn),
        .level(level[1]), .level_chg(level_chg[1]), .seg_n(seg_n[1])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw history, hold duration and level arithmetic.
    bit [D+1:0] hist    [2];
    bit         m_db    [2];
    int         m_held  [2];
    bit         m_step  [2];
    int         m_level [2];
    bit         m_chg   [2];
    logic [6:0] m_seg   [2];

    function automatic int next_level(int lv, bit up, bit dn, bit wrap);
        if (up && !dn) return (lv == MAXL) ? (wrap ? 0 : lv) : lv + 1;
        if (dn && !up) return (lv == 0) ? (wrap ? MAXL : lv) : lv - 1;
        return lv;
    endfunction

    always begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                hist[k] = '0; m_db[k] = 1'b0; m_held[k] = 0; m_step[k] = 1'b0;
                m_level[k] = 0; m_chg[k] = 1'b0; m_seg[k] = GLYPH[0];
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int nl;
                m_seg[k] = GLYPH[m_level[k]];
                nl = next_level(m_level[k], m_step[0], m_step[1], k == 0);
                m_chg[k] = (nl != m_level[k]);
                m_level[k] = nl;
            end
            for (int b = 0; b < 2; b++) begin
                bit flip, was;
                was = m_db[b];
                hist[b] = {hist[b][D:0], (b == 0) ? btn_up : btn_dn};
                // Synced value lags raw by two samples; flip after D straight disagreements.
                flip = 1'b1;
                for (int j = 2; j <= D + 1; j++) if (hist[b][j] == m_db[b]) flip = 1'b0;
                if (flip) m_db[b] = !m_db[b];
                m_held[b] = !m_db[b] ? 0 : (was ? m_held[b] + 1 : 0);
                m_step[b] = m_db[b] && (m_held[b] == 0 ||
                            (m_held[b] >= RD && (m_held[b] - RD) % RR == 0));
            end
        end
    end

    always begin
        @(negedge clk);
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_level%0d", k), 32'(level[k]), 32'(m_level[k]));
                chk($sformatf("model_chg%0d", k), 32'(level_chg[k]), 32'(m_chg[k]));
                chk($sformatf("model_seg%0d", k), 32'(seg_n[k]), 32'(m_seg[k]));
            end
        end
    end

    task automatic do_reset;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic clear_count;
        cyc = 0;
        pulses = 0;
        first_at = -1;
    endtask

    task automatic run(input int n, input int k);
        repeat (n) begin
            @(negedge clk);
            cyc++;
            if (level_chg[k]) begin
                pulses++;
                if (first_at < 0) first_at = cyc;
            end
        end
    endtask

    initial begin
        do_reset();

        // Clean press held 10 cycles.
        clear_count();
        btn_up = 1'b1;
        run(10, 0);
        btn_up = 1'b0;
        run(10, 0);
        chk("clean_first_chg", 32'(first_at), 32'd7);
        chk("clean_pulses", 32'(pulses), 32'd1);
        chk("clean_level", 32'(level[0]), 32'd1);
        chk("clean_seg", 32'(seg_n[0]), 32'h79);

        // Bouncy press: six 2-cycle toggles, then stable high.
        do_reset();
        clear_count();
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0);
            run(2, 0);
        end
        btn_up = 1'b1;
        run(15, 0);
        btn_up = 1'b0;
        run(15, 0);
        chk("bounce_pulses", 32'(pulses), 32'd1);
        chk("bounce_level", 32'(level[0]), 32'd1);

        // Hold-to-repeat from 0.
        do_reset();
        clear_count();
        btn_up = 1'b1;
        run(58, 0);
        chk("repeat_level", 32'(level[0]), 32'd8);
        chk("repeat_pulses", 32'(pulses), 32'd8);
        chk("repeat_first", 32'(first_at), 32'd7);
        run(2, 0);
        btn_up = 1'b0;
        run(20, 0);
        chk("repeat_top_wrap", 32'(level[0]), 32'd9);
        chk("repeat_top_sat", 32'(level[1]), 32'd9);

        // Bounds: up at MAX, then down.
        clear_count();
        btn_up = 1'b1;
        run(8, 1);
        btn_up = 1'b0;
        run(15, 1);
        chk("wrap_up_level", 32'(level[0]), 32'd0);
        chk("sat_up_level", 32'(level[1]), 32'd9);
        chk("sat_up_pulses", 32'(pulses), 32'd0);
        btn_dn = 1'b1;
        run(8, 1);
        btn_dn = 1'b0;
        run(15, 1);
        chk("wrap_dn_level", 32'(level[0]), 32'd9);
        chk("sat_dn_level", 32'(level[1]), 32'd8);

        // Both buttons together cancel.
        clear_count();
        btn_up = 1'b1;
        btn_dn = 1'b1;
        run(8, 0);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        run(15, 0);
        chk("both_pulses", 32'(pulses), 32'd0);
        chk("both_level", 32'(level[0]), 32'd9);

        // Random button traffic, short bursts mimic bounce.
        for (int s = 0; s < 40; s++) begin
            btn_up = 1'($urandom_range(0, 1));
            btn_dn = 1'($urandom_range(0, 1));
            run(($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : $urandom_range(1, 70), 0);
        end

        // Asynchronous reset mid-hold, button kept down through deassertion.
        btn_up = 1'b1;
        btn_dn = 1'b0;
        run(30, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("arst_level%0d", k), 32'(level[k]), 32'd0);
            chk($sformatf("arst_chg%0d", k), 32'(level_chg[k]), 32'd0);
            chk($sformatf("arst_seg%0d", k), 32'(seg_n[k]), 32'h40);
        end
        @(negedge clk);
        rst = 1'b0;
        clear_count();
        run(10, 0);
        chk("arst_refirst", 32'(first_at), 32'd7);
        chk("arst_relevel", 32'(level[0]), 32'd1);
        btn_up = 1'b0;
        run(15, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
